// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command stage and result FIFO wrapped around a 4-bit combinational ALU.
//   Accepts {opcode,a,b} on a valid/ready handshake and registers it onto the ALU pins.
//   One cycle later it captures the ALU result into a DEPTH-entry FIFO, which is drained
//   over a second valid/ready handshake.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   in_valid/in_ready               command handshake; in_opcode, in_a, in_b payload
//   alu_opcode/alu_a/alu_b          registered command driven to the ALU
//   alu_result                      combinational ALU result (2*DATA_W bits)
//   out_valid/out_ready             result handshake; out_data, out_err payload of FIFO head
//   mismatch                        sticky ALU self-check flag
// Optional feature: define ALU_CHECK_EN to build the ALU result checker; otherwise
// mismatch is tied low and no model logic exists.
module alu_cmd_sequencer #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_opcode,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    output logic [2:0]            alu_opcode,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic [2*DATA_W-1:0]   alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_data,
    output logic                  out_err,
    output logic                  mismatch
);

    localparam int unsigned RES_W = 2 * DATA_W;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    typedef struct packed {
        logic             err;
        logic [RES_W-1:0] data;
    } entry_t;

    logic [0:0]        state_q, state_d;
    logic [2:0]        alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic   accept;
    logic   push;
    logic   pop;
    entry_t push_entry;

    // Handshake qualifiers; a push happens on every edge that ends EXEC.
    always_comb begin
        accept = (state_q == S_IDLE) && in_valid && in_ready_q;
        push   = (state_q == S_EXEC);
        pop    = out_valid_q && out_ready;
        push_entry.err  = (alu_opcode_q == 3'b000);
        // Opcode 000 leaves the ALU output undefined, so it is replaced by zero.
        push_entry.data = push_entry.err ? '0 : alu_result;
    end

    // Next-state: FSM, ALU operand registers, FIFO storage/pointers/count.
    always_comb begin
        state_d      = state_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_opcode_d = in_opcode;
                    alu_a_d      = in_a;
                    alu_b_d      = in_b;
                    state_d      = S_EXEC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Ready/valid are registered from next-cycle state and occupancy.
        in_ready_d  = (state_d == S_IDLE) && (count_d < CNT_W'(DEPTH));
        out_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign out_data   = mem_q[rd_ptr_q].data;
    assign out_err    = mem_q[rd_ptr_q].err;

`ifdef ALU_CHECK_EN
    logic             mismatch_q, mismatch_d;
    logic [RES_W-1:0] model_result;
    logic [RES_W-1:0] ext_a;
    logic [RES_W-1:0] ext_b;

    // Reference ALU with zero-extended operands, results truncated to RES_W.
    always_comb begin
        ext_a = RES_W'(alu_a_q);
        ext_b = RES_W'(alu_b_q);
        case (alu_opcode_q)
            3'b001:  model_result = ext_a + ext_b;
            3'b010:  model_result = ext_a - ext_b;
            3'b011:  model_result = ext_a * ext_b;
            3'b100:  model_result = ~ext_a;
            3'b101:  model_result = ext_a & ext_b;
            3'b110:  model_result = ext_a | ext_b;
            3'b111:  model_result = ext_a ^ ext_b;
            default: model_result = '0;
        endcase
        mismatch_d = mismatch_q;
        if (push && (alu_opcode_q != 3'b000) && (alu_result != model_result)) begin
            mismatch_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: self-checking bench for alu_cmd_sequencer.
// Provides a behavioural 4-bit ALU on the alu_* pins, a result scoreboard, directed
// vectors, multi-cycle corner sequences and randomized traffic.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] alu_opcode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [7:0] alu_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_err;
    logic       mismatch;
    logic       force_bad;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] sb [$];
    logic       hold_prev;
    logic [8:0] held;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
        logic       err;
    } vec_t;

    vec_t vecs [8];

    alu_cmd_sequencer #(.DATA_W(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .mismatch   (mismatch)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: integer arithmetic truncated to 8 bits; opcode 000 drives junk.
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned r;
        case (op)
            3'd1:    r = x + y;
            3'd2:    r = x - y;
            3'd3:    r = x * y;
            3'd4:    r = ~x;
            3'd5:    r = x & y;
            3'd6:    r = x | y;
            3'd7:    r = x ^ y;
            default: r = 32'hA5;
        endcase
        return 8'(r);
    endfunction

    always_comb alu_result = alu_fn(alu_opcode, alu_a, alu_b) ^ {7'b0, force_bad};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard sampling just before each rising edge.
    task automatic sample();
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("pop_without_expected", 32'(out_valid), 32'd0);
                end else begin
                    chk("sb_data", 32'(out_data), 32'(sb[0][7:0]));
                    chk("sb_err", 32'(out_err), 32'(sb[0][8]));
                    void'(sb.pop_front());
                end
            end
            if (hold_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'({out_err, out_data}), 32'(held));
            end
            hold_prev = out_valid && !out_ready;
            held      = {out_err, out_data};
            if (in_valid && in_ready) begin
                sb.push_back((in_opcode == 3'd0) ? 9'h100
                             : {1'b0, alu_fn(in_opcode, in_a, in_b) ^ {7'b0, force_bad}});
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return one step after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int k = 0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) chk("send_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(output int pops);
        int k = 0;
        pops      = 0;
        out_ready = 1'b1;
        while (out_valid && k < 40) begin
            pops++;
            tick();
            k++;
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        hold_prev = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int pops;
        logic acc;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        force_bad = 1'b0;
        hold_prev = 1'b0;
        held      = '0;

        vecs[0] = '{3'd1, 4'd9,  4'd8,  8'h11, 1'b0};
        vecs[1] = '{3'd2, 4'd3,  4'd5,  8'hFE, 1'b0};
        vecs[2] = '{3'd3, 4'd15, 4'd15, 8'hE1, 1'b0};
        vecs[3] = '{3'd4, 4'd3,  4'd7,  8'hFC, 1'b0};
        vecs[4] = '{3'd0, 4'd6,  4'd2,  8'h00, 1'b1};
        vecs[5] = '{3'd5, 4'd12, 4'd10, 8'h08, 1'b0};
        vecs[6] = '{3'd6, 4'd12, 4'd3,  8'h0F, 1'b0};
        vecs[7] = '{3'd7, 4'd15, 4'd5,  8'h0A, 1'b0};

        // Reset values
        #2 rst = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        chk("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors with latency checks
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            chk("vec_alu_op", 32'(alu_opcode), 32'(vecs[i].op));
            chk("vec_alu_a", 32'(alu_a), 32'(vecs[i].a));
            chk("vec_alu_b", 32'(alu_b), 32'(vecs[i].b));
            chk("vec_exec_in_ready", 32'(in_ready), 32'd0);
            chk("vec_early_valid", 32'(out_valid), 32'd0);
            tick();
            chk("vec_out_valid", 32'(out_valid), 32'd1);
            chk("vec_out_data", 32'(out_data), 32'(vecs[i].exp));
            chk("vec_out_err", 32'(out_err), 32'(vecs[i].err));
            tick();
            chk("vec_popped", 32'(out_valid), 32'd0);
        end

        // Full FIFO, pop-to-unblock, simultaneous push/pop, refill to full, ordered drain
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(3'($urandom_range(1, 7)), 4'($urandom), 4'($urandom));
        end
        tick();
        in_valid  = 1'b1;
        in_opcode = 3'd1;
        in_a      = 4'd7;
        in_b      = 4'd6;
        for (int i = 0; i < 3; i++) begin
            chk("full_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("fifth_accepted", 32'(alu_a), 32'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send(3'd3, 4'd5, 4'd3);
        tick();
        chk("refull_in_ready", 32'(in_ready), 32'd0);
        chk("refull_out_valid", 32'(out_valid), 32'd1);
        drain(pops);
        chk("full_drain_count", 32'(pops), 32'd4);

        // Asynchronous reset with two entries queued and a command in EXEC
        out_ready = 1'b0;
        send(3'd1, 4'd1, 4'd2);
        send(3'd2, 4'd9, 4'd4);
        tick();
        send(3'd7, 4'd3, 4'd12);
        #2 rst = 1'b1;
        sb.delete();
        hold_prev = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        chk("async_out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send(3'd6, 4'd8, 4'd1);
        tick();
        chk("post_rst_first", 32'(out_data), 32'h09);
        drain(pops);
        chk("post_rst_pops", 32'(pops), 32'd1);

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 2000; c++) begin
            out_ready = ($urandom_range(0, 7) < ((c / 200) % 2 == 0 ? 6 : 1));
            if (!in_valid && $urandom_range(0, 1) == 1) begin
                in_valid  = 1'b1;
                in_opcode = 3'($urandom);
                in_a      = 4'($urandom);
                in_b      = 4'($urandom);
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        tick();
        tick();
        drain(pops);
        chk("random_mismatch", 32'(mismatch), 32'd0);

`ifdef ALU_CHECK_EN
        // Checker: one corrupted add sets a sticky flag; opcode 000 never does
        out_ready = 1'b1;
        send(3'd0, 4'd4, 4'd4);
        tick();
        chk("op0_no_mismatch", 32'(mismatch), 32'd0);
        force_bad = 1'b1;
        send(3'd1, 4'd2, 4'd3);
        tick();
        force_bad = 1'b0;
        chk("mismatch_set", 32'(mismatch), 32'd1);
        send(3'd1, 4'd2, 4'd3);
        tick();
        tick();
        chk("mismatch_sticky", 32'(mismatch), 32'd1);
        drain(pops);
        do_reset();
        chk("mismatch_cleared", 32'(mismatch), 32'd0);
`else
        do_reset();
        chk("mismatch_tied", 32'(mismatch), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
